// File: rtl/act_patch_pkg.sv
// ---------------------------------------------------------------------------
// act_patch_pkg
// Shared types for the activation patch stream controller.
//   state_t   : controller phase (IDLE -> LOAD -> RUN, RUN -> LOAD on reload)
//   SEL_*     : per-lane 2-bit source code reported on out_sel
// ---------------------------------------------------------------------------
package act_patch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_ORIG  = 2'b00;  // activation passed through
    localparam logic [1:0] SEL_FLIP  = 2'b01;  // bitwise inverted activation
    localparam logic [1:0] SEL_PATCH = 2'b10;  // value taken from patch cache
    localparam logic [1:0] SEL_ERR   = 2'b11;  // block index out of range

endpackage

// File: rtl/act_patch_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// act_patch_stream_ctrl_if
// Bundles the three streams of the patch controller plus its status outputs.
//   load_*   : cache fill stream (one N-bit entry per handshake) and reload
//   in_*     : activation block stream (M lanes, flip/patch masks, block idx)
//   out_*    : result block stream with per-lane source codes
//   error    : sticky out-of-range block flag
//   blocks_done : saturating count of delivered result blocks
// master = producer/consumer side (testbench), slave = controller side.
// ---------------------------------------------------------------------------
interface act_patch_stream_ctrl_if #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int B = 4
);
    localparam int BW = (B > 1) ? $clog2(B) : 1;

    logic                  load_valid;
    logic                  load_ready;
    logic [N-1:0]          load_data;
    logic                  reload;

    logic                  in_valid;
    logic                  in_ready;
    logic [M-1:0][N-1:0]   in_act;
    logic [M-1:0]          in_f;
    logic [M-1:0]          in_p;
    logic [BW-1:0]         in_block;

    logic                  out_valid;
    logic                  out_ready;
    logic [M-1:0][N-1:0]   out_act;
    logic [M-1:0][1:0]     out_sel;

    logic                  error;
    logic [31:0]           blocks_done;

    modport master (
        output load_valid, load_data, reload,
        output in_valid, in_act, in_f, in_p, in_block,
        output out_ready,
        input  load_ready, in_ready, out_valid, out_act, out_sel,
        input  error, blocks_done
    );

    modport slave (
        input  load_valid, load_data, reload,
        input  in_valid, in_act, in_f, in_p, in_block,
        input  out_ready,
        output load_ready, in_ready, out_valid, out_act, out_sel,
        output error, blocks_done
    );
endinterface

// File: rtl/act_lane_select.sv
// ---------------------------------------------------------------------------
// act_lane_select
// Combinational per-lane source selection.
//   act, flip, patch : lane activation and its flip/patch mask bits
//   blk_err          : block index out of range (overrides everything)
//   cache_q          : cache entry addressed for this lane
//   res, sel         : selected value and its source code
// Priority: blk_err > patch > flip > original.
// ---------------------------------------------------------------------------
module act_lane_select
    import act_patch_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] act,
    input  logic         flip,
    input  logic         patch,
    input  logic         blk_err,
    input  logic [N-1:0] cache_q,
    output logic [N-1:0] res,
    output logic [1:0]   sel
);
    always_comb begin
        res = act;
        sel = SEL_ORIG;
        if (blk_err) begin
            res = act;
            sel = SEL_ERR;
        end else if (patch) begin
            res = cache_q;
            sel = SEL_PATCH;
        end else if (flip) begin
            res = ~act;
            sel = SEL_FLIP;
        end
    end
endmodule

// File: rtl/act_patch_stream_ctrl.sv
// ---------------------------------------------------------------------------
// act_patch_stream_ctrl
// Fills a B*M-entry patch cache from the load stream, then transforms
// activation blocks lane by lane (patch / flip / pass) with one cycle of
// latency behind a ready/valid output register.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : act_patch_stream_ctrl_if.slave (load, in, out streams + status)
// A reload in RUN waits until the output register can be freed, so an
// unconsumed result is never dropped; while it waits it stays pending.
// ---------------------------------------------------------------------------
module act_patch_stream_ctrl
    import act_patch_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4,
    parameter int B = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    act_patch_stream_ctrl_if.slave  bus
);
    localparam int             BW   = (B > 1) ? $clog2(B) : 1;
    localparam int             D    = B * M;
    localparam int             IW   = $clog2(D);
    localparam logic [IW-1:0]  LAST = IW'(D - 1);

    state_t              state, state_nx;
    logic [IW-1:0]       load_idx;
    logic                reload_pend;
    logic [N-1:0]        cache [D];

    logic                load_ready_c, in_ready_c, reload_take;
    logic                load_fire, accept, drain, free, reload_req;
    logic                blk_err;
    logic [BW-1:0]       blk_sel;
    logic [M-1:0][N-1:0] lane_act;
    logic [M-1:0][1:0]   lane_sel;

    logic                out_valid_q, error_q;
    logic [M-1:0][N-1:0] out_act_q;
    logic [M-1:0][1:0]   out_sel_q;
    logic [31:0]         blocks_done_q;

    assign free       = !out_valid_q || bus.out_ready;
    assign drain      = out_valid_q && bus.out_ready;
    assign reload_req = bus.reload || reload_pend;
    assign load_fire  = bus.load_valid && load_ready_c;
    assign accept     = bus.in_valid && in_ready_c;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        load_ready_c = 1'b0;
        in_ready_c   = 1'b0;
        reload_take  = 1'b0;
        case (state)
            IDLE: state_nx = LOAD;
            LOAD: begin
                load_ready_c = 1'b1;
                // A reload on the final write restarts the fill instead.
                if (!bus.reload && bus.load_valid && load_idx == LAST)
                    state_nx = RUN;
            end
            RUN: begin
                if (reload_req && free) begin
                    reload_take = 1'b1;
                    state_nx    = LOAD;
                end else begin
                    in_ready_c  = free;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.load_ready = load_ready_c;
    assign bus.in_ready   = in_ready_c;

    // ---------------- fill index / reload tracking ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_idx    <= '0;
            reload_pend <= 1'b0;
        end else begin
            if (state == IDLE || (state == LOAD && bus.reload) || reload_take)
                load_idx <= '0;
            else if (load_fire)
                load_idx <= (load_idx == LAST) ? '0 : load_idx + 1'b1;

            // Pending only survives in RUN while the output is blocked.
            reload_pend <= (state == RUN) && reload_req && !free;
        end
    end

    // Cache contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (load_fire) cache[load_idx] <= bus.load_data;
    end

    // ---------------- lane datapath ----------------
    assign blk_err = 32'(bus.in_block) >= B;
    // Out-of-range blocks read entry 0; the result is discarded anyway.
    assign blk_sel = blk_err ? '0 : bus.in_block;

    for (genvar i = 0; i < M; i++) begin : g_lane
        logic [IW-1:0] ridx;
        assign ridx = IW'(32'(blk_sel) * M + i);

        act_lane_select #(.N(N)) u_sel (
            .act     (bus.in_act[i]),
            .flip    (bus.in_f[i]),
            .patch   (bus.in_p[i]),
            .blk_err (blk_err),
            .cache_q (cache[ridx]),
            .res     (lane_act[i]),
            .sel     (lane_sel[i])
        );
    end

    // ---------------- output register / status ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_act_q     <= '0;
            out_sel_q     <= '0;
            error_q       <= 1'b0;
            blocks_done_q <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_act_q   <= lane_act;
                out_sel_q   <= lane_sel;
                if (blk_err) error_q <= 1'b1;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
            if (drain && blocks_done_q != '1)
                blocks_done_q <= blocks_done_q + 32'd1;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_act     = out_act_q;
    assign bus.out_sel     = out_sel_q;
    assign bus.error       = error_q;
    assign bus.blocks_done = blocks_done_q;
endmodule

// File: tb/tb_act_patch_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_act_patch_stream_ctrl
// Directed bench for act_patch_stream_ctrl. dut4 (N=16,M=4,B=4) is tracked
// cycle by cycle by a behavioural model; dut3 (B=3) covers the out-of-range
// block path with literal expectations. Inputs change 1 time unit after a
// rising edge; outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_act_patch_stream_ctrl;
    localparam int N = 16;
    localparam int M = 4;
    localparam int B = 4;
    localparam int D = B * M;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reset3 = 1'b0;
    always #5 clk = ~clk;

    act_patch_stream_ctrl_if #(.N(N), .M(M), .B(B)) i4 ();
    act_patch_stream_ctrl_if #(.N(N), .M(M), .B(3)) i3 ();

    act_patch_stream_ctrl #(.N(N), .M(M), .B(B)) dut4 (.clk(clk), .reset(reset),  .bus(i4));
    act_patch_stream_ctrl #(.N(N), .M(M), .B(3)) dut3 (.clk(clk), .reset(reset3), .bus(i3));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model of dut4 ----------------
    int                  m_mode = 0;   // 0 idle, 1 filling, 2 streaming
    int                  m_idx  = 0;
    bit                  m_pend = 0, m_ov = 0, m_err = 0;
    logic [31:0]         m_bd   = '0;
    logic [M-1:0][N-1:0] m_act  = '0;
    logic [M-1:0][1:0]   m_sel  = '0;
    logic [N-1:0]        m_cache [D];

    function automatic bit exp_in_ready();
        return (m_mode == 2) && (!m_ov || i4.out_ready) && !(i4.reload || m_pend);
    endfunction

    function automatic bit exp_load_ready();
        return m_mode == 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_idx = 0; m_pend = 0; m_ov = 0; m_err = 0;
            m_bd = '0; m_act = '0; m_sel = '0;
        end else begin
            bit fr, dr, acc, rq;
            int blk;
            fr  = !m_ov || i4.out_ready;
            dr  = m_ov && i4.out_ready;
            acc = i4.in_valid && exp_in_ready();
            rq  = i4.reload || m_pend;
            if (m_mode == 0) begin
                m_mode = 1; m_idx = 0;
            end else if (m_mode == 1) begin
                if (i4.load_valid) m_cache[m_idx] = i4.load_data;
                if (i4.reload) m_idx = 0;
                else if (i4.load_valid) begin
                    if (m_idx == D - 1) begin m_idx = 0; m_mode = 2; end
                    else m_idx++;
                end
            end else begin
                if (rq && fr) begin m_mode = 1; m_idx = 0; m_pend = 0; end
                else if (i4.reload) m_pend = 1;
            end
            if (acc) begin
                blk = int'(i4.in_block);
                for (int l = 0; l < M; l++) begin
                    if (blk >= B) begin
                        m_act[l] = i4.in_act[l]; m_sel[l] = 2'b11; m_err = 1;
                    end else if (i4.in_p[l]) begin
                        m_act[l] = m_cache[blk * M + l]; m_sel[l] = 2'b10;
                    end else if (i4.in_f[l]) begin
                        m_act[l] = ~i4.in_act[l]; m_sel[l] = 2'b01;
                    end else begin
                        m_act[l] = i4.in_act[l]; m_sel[l] = 2'b00;
                    end
                end
                m_ov = 1;
            end else if (dr) begin
                m_ov = 0;
            end
            if (dr && m_bd != 32'hFFFF_FFFF) m_bd = m_bd + 32'd1;
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        chk("m_in_ready",    64'(i4.in_ready),    64'(exp_in_ready()));
        chk("m_load_ready",  64'(i4.load_ready),  64'(exp_load_ready()));
        chk("m_out_valid",   64'(i4.out_valid),   64'(m_ov));
        chk("m_error",       64'(i4.error),       64'(m_err));
        chk("m_blocks_done", 64'(i4.blocks_done), 64'(m_bd));
        if (m_ov || !reset) begin
            chk("m_out_act", 64'(i4.out_act), 64'(m_act));
            chk("m_out_sel", 64'(i4.out_sel), 64'(m_sel));
        end
    end

    // ---------------- stimulus helpers (start at posedge+1) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load4(input logic [15:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            int b;
            b = 0;
            i4.load_valid = 1'b1;
            i4.load_data  = base + 16'(k);
            @(negedge clk);
            while (!i4.load_ready && b < 40) begin b++; @(negedge clk); end
            if (!i4.load_ready) begin
                n_assert++; n_fail++;
                $display("FAIL load_timeout: load_ready got 0 expected 1");
            end
            step();
        end
        i4.load_valid = 1'b0;
    endtask

    task automatic send4(input logic [1:0] blk, input logic [3:0] p, input logic [3:0] f,
                         input logic [15:0] a);
        int b;
        b = 0;
        i4.in_valid = 1'b1; i4.in_block = blk; i4.in_p = p; i4.in_f = f;
        i4.in_act = {a, a, a, a};
        @(negedge clk);
        while (!i4.in_ready && b < 40) begin b++; @(negedge clk); end
        if (!i4.in_ready) begin
            n_assert++; n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        step();
        i4.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        i4.load_valid = 0; i4.load_data = '0; i4.reload = 0; i4.in_valid = 0;
        i4.in_act = '0; i4.in_f = '0; i4.in_p = '0; i4.in_block = '0; i4.out_ready = 0;
        i3.load_valid = 0; i3.load_data = '0; i3.reload = 0; i3.in_valid = 0;
        i3.in_act = '0; i3.in_f = '0; i3.in_p = '0; i3.in_block = '0; i3.out_ready = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid",   64'(i4.out_valid),   64'd0);
        chk("rst_out_act",     64'(i4.out_act),     64'd0);
        chk("rst_out_sel",     64'(i4.out_sel),     64'd0);
        chk("rst_error",       64'(i4.error),       64'd0);
        chk("rst_blocks_done", 64'(i4.blocks_done), 64'd0);
        chk("rst_load_ready",  64'(i4.load_ready),  64'd0);
        chk("rst_in_ready",    64'(i4.in_ready),    64'd0);
        chk("rst_b3_error",    64'(i3.error),       64'd0);
        step();
        reset = 1'b1;

        // Fill 0x0100..0x010F
        load4(16'h0100, 16);
        i4.out_ready = 1'b1;
        @(negedge clk);
        chk("fill_load_ready_drop", 64'(i4.load_ready), 64'd0);
        chk("fill_in_ready_up",     64'(i4.in_ready),   64'd1);

        // Mixed patch/flip/orig on block 2
        step();
        send4(2'd2, 4'b1000, 4'b0011, 16'h00F0);
        @(negedge clk);
        chk("mix_out_act", 64'(i4.out_act), {16'h010B, 16'h00F0, 16'hFF0F, 16'hFF0F});
        chk("mix_out_sel", 64'(i4.out_sel), 64'h85);
        step();  // drains, blocks_done = 1

        // Backpressure
        i4.out_ready = 1'b0;
        send4(2'd0, 4'b0001, 4'b0010, 16'h1234);           // A
        i4.in_valid = 1'b1; i4.in_block = 2'd1; i4.in_p = 4'b1111; i4.in_f = 4'b0000;
        i4.in_act = '0;                                     // B waiting
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready",    64'(i4.in_ready),    64'd0);
            chk("bp_out_act",     64'(i4.out_act),     {16'h1234, 16'h1234, 16'hEDCB, 16'h0100});
            chk("bp_out_sel",     64'(i4.out_sel),     64'h06);
            chk("bp_blocks_done", 64'(i4.blocks_done), 64'd1);
        end
        step();
        i4.out_ready = 1'b1;
        step();                                             // A out, B in
        i4.in_block = 2'd3; i4.in_p = 4'b0000; i4.in_f = 4'b1111;   // C
        @(negedge clk);
        chk("bp_bd2",  64'(i4.blocks_done), 64'd2);
        chk("bp_actB", 64'(i4.out_act), {16'h0107, 16'h0106, 16'h0105, 16'h0104});
        step();                                             // B out, C in
        i4.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_bd3",  64'(i4.blocks_done), 64'd3);
        chk("bp_actC", 64'(i4.out_act), {4{16'hFFFF}});
        chk("bp_selC", 64'(i4.out_sel), 64'h55);
        step();
        @(negedge clk);
        chk("bp_bd4", 64'(i4.blocks_done), 64'd4);
        chk("bp_ov0", 64'(i4.out_valid),   64'd0);

        // Reload held off by a stalled output
        step();
        i4.out_ready = 1'b0;
        send4(2'd0, 4'b0000, 4'b0000, 16'h5555);
        i4.reload = 1'b1;
        step();
        i4.reload = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rl_stay_run_lr", 64'(i4.load_ready), 64'd0);
            chk("rl_stay_run_ov", 64'(i4.out_valid),  64'd1);
        end
        step();
        i4.out_ready = 1'b1;
        @(negedge clk);
        chk("rl_pending_blocks_in", 64'(i4.in_ready), 64'd0);
        step();
        @(negedge clk);
        chk("rl_load_ready", 64'(i4.load_ready),  64'd1);
        chk("rl_ov_clear",   64'(i4.out_valid),   64'd0);
        chk("rl_bd5",        64'(i4.blocks_done), 64'd5);
        step();
        load4(16'h0200, 16);
        @(negedge clk);
        chk("rl_run_again", 64'(i4.in_ready), 64'd1);
        step();
        send4(2'd0, 4'b0001, 4'b0000, 16'h0000);
        @(negedge clk);
        chk("rl_entry0", 64'(i4.out_act), {16'h0000, 16'h0000, 16'h0000, 16'h0200});
        chk("rl_sel0",   64'(i4.out_sel), 64'h02);
        step();
        send4(2'd3, 4'b1111, 4'b0000, 16'h0000);
        @(negedge clk);
        chk("rl_entry15", 64'(i4.out_act), {16'h020F, 16'h020E, 16'h020D, 16'h020C});

        // Reset in the middle of a fill
        step();
        i4.reload = 1'b1;
        step();
        i4.reload = 1'b0;
        load4(16'h0300, 7);
        reset = 1'b0;
        #1;
        chk("mr_out_valid",   64'(i4.out_valid),   64'd0);
        chk("mr_out_act",     64'(i4.out_act),     64'd0);
        chk("mr_out_sel",     64'(i4.out_sel),     64'd0);
        chk("mr_error",       64'(i4.error),       64'd0);
        chk("mr_blocks_done", 64'(i4.blocks_done), 64'd0);
        chk("mr_load_ready",  64'(i4.load_ready),  64'd0);
        chk("mr_in_ready",    64'(i4.in_ready),    64'd0);
        step();
        reset = 1'b1;
        load4(16'h0400, 16);
        @(negedge clk);
        chk("mr_refill_run", 64'(i4.in_ready), 64'd1);
        step();
        send4(2'd1, 4'b1111, 4'b0000, 16'h0000);
        @(negedge clk);
        chk("mr_refill_blk1", 64'(i4.out_act), {16'h0407, 16'h0406, 16'h0405, 16'h0404});

        // B=3 build: out-of-range block
        step();
        reset3 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int b;
            b = 0;
            i3.load_valid = 1'b1;
            i3.load_data  = 16'h0100 + 16'(k);
            @(negedge clk);
            while (!i3.load_ready && b < 40) begin b++; @(negedge clk); end
            if (!i3.load_ready) begin
                n_assert++; n_fail++;
                $display("FAIL b3_load_timeout: load_ready got 0 expected 1");
            end
            step();
        end
        i3.load_valid = 1'b0;
        i3.out_ready  = 1'b1;
        i3.in_valid = 1'b1; i3.in_block = 2'd3; i3.in_p = 4'b1111; i3.in_f = 4'b1111;
        i3.in_act = {4{16'h00AA}};
        @(negedge clk);
        chk("b3_in_ready", 64'(i3.in_ready), 64'd1);
        step();
        i3.in_block = 2'd0; i3.in_p = 4'b0001; i3.in_f = 4'b0000;
        i3.in_act = {4{16'h0011}};
        @(negedge clk);
        chk("b3_err_sel", 64'(i3.out_sel),   64'hFF);
        chk("b3_err_act", 64'(i3.out_act),   {4{16'h00AA}});
        chk("b3_err_set", 64'(i3.error),     64'd1);
        chk("b3_err_ov",  64'(i3.out_valid), 64'd1);
        step();
        i3.in_valid = 1'b0;
        @(negedge clk);
        chk("b3_ok_act",    64'(i3.out_act), {16'h0011, 16'h0011, 16'h0011, 16'h0100});
        chk("b3_ok_sel",    64'(i3.out_sel), 64'h02);
        chk("b3_err_stick", 64'(i3.error),   64'd1);
        repeat (3) step();
        @(negedge clk);
        chk("b3_err_stick2", 64'(i3.error),       64'd1);
        chk("b3_bd",         64'(i3.blocks_done), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/act_patch_stream_ctrl.md
ACT_PATCH_STREAM_CTRL -- requirements
Module: act_patch_stream_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, activation width in bits (N >= 2).
REQ-002 SHALL have parameter M, default 4, lanes per activation block (power of 2, >= 2).
REQ-003 SHALL have parameter B, default 4, patch-cache depth in blocks (>= 1); cache holds B*M entries.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have ports load_valid input 1, load_ready output 1, load_data input N: patch-cache fill stream, one entry per handshake.
REQ-007 SHALL have port reload  input  1  single-cycle request to refill the cache.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1, in_act input [M][N], in_f input [M], in_p input [M], in_block input clog2(B) (min 1): activation stream.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_act output [M][N], out_sel output [M][2]: result stream with per-lane source code.
REQ-010 SHALL have ports error output 1 (sticky) and blocks_done output 32 (count of accepted result blocks).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-012 SHALL move IDLE->LOAD on the first cycle after reset release.
REQ-013 In LOAD, load_ready SHALL be 1; each load_valid&&load_ready cycle SHALL write load_data to cache[load_idx] and increment load_idx (0..B*M-1).
REQ-014 When the write at load_idx = B*M-1 occurs, load_idx SHALL wrap to 0 and the FSM SHALL enter RUN the next cycle.
REQ-015 In RUN, load_ready SHALL be 0; in_ready SHALL equal (!out_valid || out_ready); in IDLE/LOAD in_ready SHALL be 0.
REQ-016 On in_valid&&in_ready, each lane i SHALL be registered into out_act[i] with 1-cycle latency: p[i]=1 -> cache[in_block*M+i], sel=2'b10; else f[i]=1 -> bitwise NOT of in_act[i], sel=2'b01; else in_act[i], sel=2'b00 (p has priority over f).
REQ-017 If in_block >= B at acceptance, all lanes SHALL output in_act unchanged with sel=2'b11 and error SHALL set to 1.
REQ-018 out_valid SHALL set on acceptance and clear on out_valid&&out_ready without a same-cycle acceptance; out_act/out_sel SHALL hold stable while out_valid&&!out_ready.
REQ-019 blocks_done SHALL increment by 1 on each out_valid&&out_ready and saturate at 2^32-1.
REQ-020 reload in RUN SHALL be honoured only when out_valid=0 or out_ready=1 that cycle: FSM -> LOAD, load_idx -> 0, no acceptance that cycle; otherwise reload SHALL remain pending until honoured.
REQ-021 reload in IDLE or LOAD SHALL restart the fill at load_idx 0 (cache contents not cleared).
REQ-022 error SHALL clear only on reset.

Reset
REQ-023 On reset: state IDLE, load_idx 0, reload pending 0, out_valid 0, out_act all 0, out_sel all 0, error 0, blocks_done 0, load_ready 0, in_ready 0.
REQ-024 Cache storage SHALL not require reset; reset asserted mid-LOAD or mid-RUN SHALL abort immediately and the next fill SHALL start at index 0.

Structure
REQ-025 A shared package act_patch_pkg SHALL hold the state_t enum and the 2-bit source codes SEL_ORIG, SEL_FLIP, SEL_PATCH, SEL_ERR.
REQ-026 The per-lane priority selection SHALL be a combinational sub-module act_lane_select instantiated M times.
REQ-027 Cache SHALL be a flat register array of B*M entries of N bits indexed by block*M+lane.

Verification
REQ-028 Reset release, feed 16 entries 0x0100..0x010F with load_valid=1 (N=16,M=4,B=4) -> load_ready drops after 16th, in_ready=1 next cycle.
REQ-029 in_block=2, p=1000b, f=0011b, in_act all 0x00F0 -> next cycle out_act = {0x010B,0x00F0,0xFF0F,0xFF0F} (lane3..0), out_sel={10,00,01,01}.
REQ-030 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_act stable, blocks_done unchanged; out_ready=1 -> one transfer per cycle, blocks_done +1 each.
REQ-031 B=3 build, in_block=3 -> out_sel all 11, out_act = in_act, error=1 and stays 1 after further valid blocks.
REQ-032 reload pulsed while out_valid=1,out_ready=0 -> stays RUN; on out_ready=1 enters LOAD, next fill writes cache[0] first.
REQ-033 reset asserted after 7 load writes -> all outputs per REQ-023; refill of 16 entries then reaches RUN normally.
